// File: rtl/usb_pkg.sv
// Shared USB receive-path types: PID encodings, packet classes and the PID classifier.
package usb_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [3:0] {
    OUT   = 4'b0001,
    IN    = 4'b1001,
    DATA0 = 4'b0011,
    DATA1 = 4'b1011,
    ACK   = 4'b0010,
    NAK   = 4'b1010,
    STALL = 4'b1110
  } pid_t;

  typedef enum logic [1:0] {
    TOKEN     = 2'd0,
    DATA      = 2'd1,
    HANDSHAKE = 2'd2
  } pkt_class_t;

  typedef struct packed {
    logic       valid;
    pkt_class_t cls;
  } pid_info_t;

  // PIDs outside the token/data/handshake set are not accepted by this receiver.
  function automatic pid_info_t classify_pid(input logic [3:0] pid);
    pid_info_t info;
    info.valid = 1'b1;
    info.cls   = TOKEN;
    case (pid)
      OUT, IN:          info.cls = TOKEN;
      DATA0, DATA1:     info.cls = DATA;
      ACK, NAK, STALL:  info.cls = HANDSHAKE;
      default:          info.valid = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/rx_byte_counter.sv
// Payload byte counter with clear, saturating increment and class-bound compares.
module rx_byte_counter #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [CW-1:0] lim_min_i,
  input  logic [CW-1:0] lim_max_i,
  output logic [CW-1:0] count_o,
  output logic          at_max_o,
  output logic          in_range_o
);

  logic [CW-1:0] count_q, count_d;

  assign at_max_o   = (count_q == lim_max_i);
  assign in_range_o = (count_q >= lim_min_i) && (count_q <= lim_max_i);
  assign count_o    = count_q;

  // The limit guard keeps the count from ever wrapping even if inc is misused.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !at_max_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive sequencer: frames SYNC/PID/payload/EOP, drives the PID
// detector, writes payload bytes to the FIFO and reports done or a sticky error.
module usb_rx_ctrl #(
  parameter int         MAX_DATA  = 64,
  parameter logic [7:0] SYNC_BYTE = usb_pkg::SYNC_BYTE,
  parameter int         CW        = $clog2(MAX_DATA + 3)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          d_edge,
  input  logic          eop,
  input  logic          shift_enable,
  input  logic          byte_received,
  input  logic [7:0]    rcv_data,
  input  logic [3:0]    PID,
  input  logic          PID_err,
  output logic          PID_set,
  output logic          PID_clear,
  output logic          rcving,
  output logic          w_enable,
  output logic          r_error,
  output logic          rx_packet_done,
  output logic [CW-1:0] byte_count
);
  import usb_pkg::*;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CLEAR     = 4'd1;
  localparam logic [3:0] S_SYNC_WAIT = 4'd2;
  localparam logic [3:0] S_PID_WAIT  = 4'd3;
  localparam logic [3:0] S_PID_LOAD  = 4'd4;
  localparam logic [3:0] S_PID_CHECK = 4'd5;
  localparam logic [3:0] S_PAYLOAD   = 4'd6;
  localparam logic [3:0] S_STORE     = 4'd7;
  localparam logic [3:0] S_EOP_CHECK = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;
  localparam logic [3:0] S_ERR       = 4'd10;
  localparam logic [3:0] S_ERR_IDLE  = 4'd11;

  logic [3:0]    state_q, state_d;
  logic          r_error_q, r_error_d;
  pkt_class_t    cls_q, cls_d;
  logic          eop_s;
  pid_info_t     pid_info;
  logic          cnt_clr, cnt_inc, cnt_at_max, cnt_in_range;
  logic [CW-1:0] lim_min, lim_max;

  assign eop_s    = eop & shift_enable;
  assign pid_info = classify_pid(PID);

  always_comb begin
    lim_min = '0;
    lim_max = '0;
    case (cls_q)
      TOKEN:     begin lim_min = CW'(2); lim_max = CW'(2);            end
      HANDSHAKE: begin lim_min = '0;     lim_max = '0;                end
      default:   begin lim_min = CW'(2); lim_max = CW'(MAX_DATA + 2); end
    endcase
  end

  rx_byte_counter #(.CW(CW)) u_byte_counter (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .lim_min_i  (lim_min),
    .lim_max_i  (lim_max),
    .count_o    (byte_count),
    .at_max_o   (cnt_at_max),
    .in_range_o (cnt_in_range)
  );

  always_comb begin
    state_d   = state_q;
    r_error_d = r_error_q;
    cls_d     = cls_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      S_IDLE:      if (d_edge) state_d = S_CLEAR;
      S_CLEAR: begin
        cnt_clr   = 1'b1;
        r_error_d = 1'b0;
        state_d   = S_SYNC_WAIT;
      end
      S_SYNC_WAIT: begin
        if (byte_received) begin
          state_d = (rcv_data == SYNC_BYTE) ? S_PID_WAIT : S_ERR;
        end else if (eop_s) begin
          state_d   = S_ERR_IDLE;
          r_error_d = 1'b1;
        end
      end
      S_PID_WAIT: begin
        if (byte_received) begin
          state_d = S_PID_LOAD;
        end else if (eop_s) begin
          state_d   = S_ERR_IDLE;
          r_error_d = 1'b1;
        end
      end
      S_PID_LOAD:  state_d = S_PID_CHECK;
      S_PID_CHECK: begin
        if (PID_err || !pid_info.valid) begin
          state_d = S_ERR;
        end else begin
          cls_d   = pid_info.cls;
          state_d = S_PAYLOAD;
        end
      end
      // A byte arriving with the count already at the class limit is an overrun.
      S_PAYLOAD: begin
        if (byte_received && eop_s) begin
          state_d = S_ERR;
        end else if (byte_received) begin
          state_d = cnt_at_max ? S_ERR : S_STORE;
        end else if (eop_s) begin
          state_d = S_EOP_CHECK;
        end
      end
      S_STORE: begin
        cnt_inc = 1'b1;
        state_d = S_PAYLOAD;
      end
      S_EOP_CHECK: begin
        if (cnt_in_range) begin
          state_d = S_DONE;
        end else begin
          r_error_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DONE:      state_d = S_IDLE;
      S_ERR: begin
        r_error_d = 1'b1;
        if (eop_s) state_d = S_ERR_IDLE;
      end
      S_ERR_IDLE:  if (d_edge) state_d = S_CLEAR;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      r_error_q <= 1'b0;
      cls_q     <= TOKEN;
    end else begin
      state_q   <= state_d;
      r_error_q <= r_error_d;
      cls_q     <= cls_d;
    end
  end

  // Strobes decode straight from the state register, so reset forces them low at once.
  assign PID_clear      = (state_q == S_CLEAR);
  assign PID_set        = (state_q == S_PID_LOAD);
  assign w_enable       = (state_q == S_STORE);
  assign rx_packet_done = (state_q == S_DONE);
  assign rcving         = (state_q != S_IDLE) && (state_q != S_DONE) &&
                          (state_q != S_ERR_IDLE);
  assign r_error        = r_error_q;

endmodule
